// File: rtl/tlk2711_rx_deframer.sv
// TLK2711 receive deframer: acquires sync on idle K-codes, strips SOF/EOF framing and
// packs 16-bit payload words into 64-bit beats with word-keep, last, error and length.
//   state | meaning
//   LOS   | no sync; counting consecutive idles
//   IDLE  | synced, between frames
//   FRAME | collecting payload words
//   DROP  | frame hit MAX_WORDS; discarding until EOF/IDLE/SOF
module tlk2711_rx_deframer #(
  parameter int SYNC_CNT   = 16,
  parameter int ERR_MAX    = 8,
  parameter int MAX_WORDS  = 4096,
  parameter int DLEN_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           i_2711_rxd,
  input  logic                  i_2711_rkmsb,
  input  logic                  i_2711_rklsb,
  output logic [63:0]           o_data,
  output logic [3:0]            o_keep,
  output logic                  o_valid,
  output logic                  o_last,
  output logic                  o_err,
  output logic [DLEN_WIDTH-1:0] o_frame_len,
  output logic                  o_sync,
  output logic                  o_loss_irq,
  output logic [31:0]           o_frame_cnt,
  output logic [15:0]           o_code_err_cnt
);

  localparam int SCW = $clog2(SYNC_CNT + 1);
  localparam int ECW = $clog2(ERR_MAX + 1);
  localparam int WCW = ($clog2(MAX_WORDS + 1) > 2) ? $clog2(MAX_WORDS + 1) : 2;

  typedef enum logic [1:0] {ST_LOS, ST_IDLE, ST_FRAME, ST_DROP} state_t;

  state_t          r_state, w_state_nx;
  logic [15:0]     r_rxd;
  logic [1:0]      r_rk;
  logic [SCW-1:0]  r_sync_cnt, w_sync_nx, w_sync_inc;
  logic [ECW-1:0]  r_err_cnt, w_err_nx, w_err_inc;
  logic [WCW-1:0]  r_word_cnt, w_wc_nx, w_wc_inc;
  logic [63:0]     r_acc, w_acc_nx, w_acc_ins;
  logic [63:0]     r_pend, w_pend_nx;
  logic            r_pend_vld, w_pend_vld_nx;
  logic            r_tail, w_tail_nx;
  logic [31:0]     r_frame_cnt, w_fcnt_nx;
  logic [15:0]     r_code_err_cnt, w_cec_nx;

  logic                  r_b_vld, w_b_vld;
  logic [63:0]           r_b_data, w_b_data;
  logic [3:0]            r_b_keep, w_b_keep;
  logic                  r_b_last, w_b_last;
  logic                  r_b_err, w_b_err;
  logic [DLEN_WIDTH-1:0] r_b_len, w_b_len;

  logic w_idle, w_sof, w_eof, w_data, w_err, w_loss;
  logic w_do_flush, w_flush_err, w_flush_acc;
  logic [1:0] w_lane;

  function automatic logic [3:0] keep_of(input logic [1:0] n);
    case (n)
      2'd1:    keep_of = 4'b0001;
      2'd2:    keep_of = 4'b0011;
      2'd3:    keep_of = 4'b0111;
      default: keep_of = 4'b1111;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rxd <= '0;
      r_rk  <= '0;
    end else begin
      r_rxd <= i_2711_rxd;
      r_rk  <= {i_2711_rkmsb, i_2711_rklsb};
    end
  end

  assign w_idle = (r_rk == 2'b01) && (r_rxd == 16'hC5BC);
  assign w_sof  = (r_rk == 2'b11) && (r_rxd == 16'hFBFB);
  assign w_eof  = (r_rk == 2'b11) && (r_rxd == 16'hFDFD);
  assign w_data = (r_rk == 2'b00);
  assign w_err  = !(w_idle || w_sof || w_eof || w_data);

  assign w_sync_inc = r_sync_cnt + SCW'(1);
  assign w_err_inc  = r_err_cnt + ECW'(1);
  assign w_wc_inc   = r_word_cnt + WCW'(1);
  assign w_lane     = r_word_cnt[1:0];
  assign w_loss     = (r_state != ST_LOS) && w_err && (w_err_inc == ECW'(ERR_MAX));

  always_comb begin
    w_acc_ins = r_acc;
    w_acc_ins[{w_lane, 4'b0000} +: 16] = r_rxd;
  end

  always_comb begin
    w_state_nx    = r_state;
    w_sync_nx     = r_sync_cnt;
    w_err_nx      = r_err_cnt;
    w_wc_nx       = r_word_cnt;
    w_acc_nx      = r_acc;
    w_pend_nx     = r_pend;
    w_pend_vld_nx = r_pend_vld;
    w_tail_nx     = r_tail;
    w_fcnt_nx     = r_frame_cnt;
    w_cec_nx      = r_code_err_cnt;
    w_b_vld       = 1'b0;
    w_b_data      = '0;
    w_b_keep      = '0;
    w_b_last      = 1'b0;
    w_b_err       = 1'b0;
    w_b_len       = '0;
    w_do_flush    = 1'b0;
    w_flush_err   = 1'b1;
    w_flush_acc   = 1'b1;

    if (r_state != ST_LOS && w_err) begin
      w_err_nx = w_err_inc;
      if (r_code_err_cnt != 16'hFFFF) w_cec_nx = r_code_err_cnt + 16'd1;
    end

    case (r_state)
      ST_LOS: begin
        if (w_idle) begin
          if (w_sync_inc == SCW'(SYNC_CNT)) begin
            w_state_nx = ST_IDLE;
            w_sync_nx  = '0;
            w_err_nx   = '0;
          end else begin
            w_sync_nx = w_sync_inc;
          end
        end else begin
          w_sync_nx = '0;
        end
      end
      ST_IDLE: begin
        if (w_sof) begin
          w_state_nx    = ST_FRAME;
          w_wc_nx       = '0;
          w_acc_nx      = '0;
          w_pend_vld_nx = 1'b0;
        end
      end
      ST_FRAME: begin
        if (w_data) begin
          w_b_vld  = r_pend_vld;
          w_b_data = r_pend;
          w_b_keep = 4'b1111;
          w_wc_nx  = w_wc_inc;
          if (w_lane == 2'd3) begin
            w_pend_nx     = w_acc_ins;
            w_pend_vld_nx = 1'b1;
            w_acc_nx      = '0;
          end else begin
            w_acc_nx      = w_acc_ins;
            w_pend_vld_nx = 1'b0;
          end
          if (w_wc_inc == WCW'(MAX_WORDS)) begin
            w_state_nx = ST_DROP;
            // A held group goes out now; the lone final word follows next cycle from DROP.
            if (r_pend_vld) begin
              w_tail_nx = 1'b1;
            end else begin
              w_b_vld       = 1'b1;
              w_b_data      = w_acc_ins;
              w_b_keep      = keep_of(w_wc_inc[1:0]);
              w_b_last      = 1'b1;
              w_b_err       = 1'b1;
              w_b_len       = DLEN_WIDTH'(w_wc_inc);
              w_pend_vld_nx = 1'b0;
              w_acc_nx      = '0;
            end
          end
        end else begin
          w_do_flush  = 1'b1;
          w_flush_err = !w_eof;
          if (w_eof) w_fcnt_nx = r_frame_cnt + 32'd1;
          if (w_sof) w_wc_nx = '0;
          else       w_state_nx = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (w_eof || w_idle) begin
          w_state_nx = ST_IDLE;
        end else if (w_sof) begin
          w_state_nx = ST_FRAME;
          w_wc_nx    = '0;
        end
        w_do_flush = r_tail;
        w_tail_nx  = 1'b0;
      end
      default: w_state_nx = ST_LOS;
    endcase

    // Loss keeps only a complete held beat; the partial group is thrown away.
    if (w_loss) begin
      w_state_nx  = ST_LOS;
      w_flush_acc = r_tail;
    end

    if (w_do_flush) begin
      w_b_vld  = r_pend_vld;
      w_b_data = r_pend;
      w_b_keep = 4'b1111;
      w_b_last = 1'b1;
      w_b_err  = w_flush_err;
      w_b_len  = DLEN_WIDTH'(r_word_cnt);
      if (!r_pend_vld && w_flush_acc && w_lane != 2'd0) begin
        w_b_vld  = 1'b1;
        w_b_data = r_acc;
        w_b_keep = keep_of(w_lane);
      end
      w_pend_vld_nx = 1'b0;
      w_acc_nx      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_LOS;
      r_sync_cnt     <= '0;
      r_err_cnt      <= '0;
      r_word_cnt     <= '0;
      r_acc          <= '0;
      r_pend         <= '0;
      r_pend_vld     <= 1'b0;
      r_tail         <= 1'b0;
      r_frame_cnt    <= '0;
      r_code_err_cnt <= '0;
      r_b_vld        <= 1'b0;
      r_b_data       <= '0;
      r_b_keep       <= '0;
      r_b_last       <= 1'b0;
      r_b_err        <= 1'b0;
      r_b_len        <= '0;
    end else begin
      r_state        <= w_state_nx;
      r_sync_cnt     <= w_sync_nx;
      r_err_cnt      <= w_err_nx;
      r_word_cnt     <= w_wc_nx;
      r_acc          <= w_acc_nx;
      r_pend         <= w_pend_nx;
      r_pend_vld     <= w_pend_vld_nx;
      r_tail         <= w_tail_nx;
      r_frame_cnt    <= w_fcnt_nx;
      r_code_err_cnt <= w_cec_nx;
      r_b_vld        <= w_b_vld;
      r_b_data       <= w_b_data;
      r_b_keep       <= w_b_keep;
      r_b_last       <= w_b_last;
      r_b_err        <= w_b_err;
      r_b_len        <= w_b_len;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid        <= 1'b0;
      o_data         <= '0;
      o_keep         <= '0;
      o_last         <= 1'b0;
      o_err          <= 1'b0;
      o_frame_len    <= '0;
      o_sync         <= 1'b0;
      o_loss_irq     <= 1'b0;
      o_frame_cnt    <= '0;
      o_code_err_cnt <= '0;
    end else begin
      o_valid <= r_b_vld;
      if (r_b_vld) begin
        o_data <= r_b_data;
        o_keep <= r_b_keep;
        o_last <= r_b_last;
        o_err  <= r_b_err;
        if (r_b_last) o_frame_len <= r_b_len;
      end
      o_sync         <= (r_state != ST_LOS);
      o_loss_irq     <= o_sync && (r_state == ST_LOS);
      o_frame_cnt    <= r_frame_cnt;
      o_code_err_cnt <= r_code_err_cnt;
    end
  end

endmodule

// File: tb/tb_tlk2711_rx_deframer.sv
// Directed bench for tlk2711_rx_deframer: a default instance plus a MAX_WORDS=8 instance
// share one symbol stream; emitted beats are collected and compared to hand-worked values.
module tb_tlk2711_rx_deframer;

  typedef struct packed {
    logic [63:0] d;
    logic [3:0]  k;
    logic        l;
    logic        e;
    logic [15:0] n;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rxd;
  logic        rkm, rkl;

  logic [63:0] o_data, m_data;
  logic [3:0]  o_keep, m_keep;
  logic        o_valid, m_valid, o_last, m_last, o_err, m_err;
  logic [15:0] o_frame_len, m_frame_len;
  logic        o_sync, m_sync, o_loss_irq, m_loss_irq;
  logic [31:0] o_frame_cnt, m_frame_cnt;
  logic [15:0] o_code_err_cnt, m_code_err_cnt;

  beat_t q[$];
  beat_t mq[$];
  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tlk2711_rx_deframer u_dut (
    .clk(clk), .rst(rst), .i_2711_rxd(rxd), .i_2711_rkmsb(rkm), .i_2711_rklsb(rkl),
    .o_data(o_data), .o_keep(o_keep), .o_valid(o_valid), .o_last(o_last), .o_err(o_err),
    .o_frame_len(o_frame_len), .o_sync(o_sync), .o_loss_irq(o_loss_irq),
    .o_frame_cnt(o_frame_cnt), .o_code_err_cnt(o_code_err_cnt)
  );

  tlk2711_rx_deframer #(.MAX_WORDS(8)) u_dut_max (
    .clk(clk), .rst(rst), .i_2711_rxd(rxd), .i_2711_rkmsb(rkm), .i_2711_rklsb(rkl),
    .o_data(m_data), .o_keep(m_keep), .o_valid(m_valid), .o_last(m_last), .o_err(m_err),
    .o_frame_len(m_frame_len), .o_sync(m_sync), .o_loss_irq(m_loss_irq),
    .o_frame_cnt(m_frame_cnt), .o_code_err_cnt(m_code_err_cnt)
  );

  always @(negedge clk) begin
    if (o_valid) q.push_back({o_data, o_keep, o_last, o_err, o_frame_len});
    if (m_valid) mq.push_back({m_data, m_keep, m_last, m_err, m_frame_len});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_beat(input bit use_m, input string tag, input int idx,
                          input logic [63:0] d, input logic [3:0] k,
                          input logic l, input logic e, input logic [15:0] n);
    beat_t b;
    int    sz;
    sz = use_m ? mq.size() : q.size();
    if (idx >= sz) begin
      chk({tag, "_present"}, 64'(sz), 64'(idx + 1));
    end else begin
      b = use_m ? mq[idx] : q[idx];
      chk({tag, "_data"}, b.d, d);
      chk({tag, "_keep"}, 64'(b.k), 64'(k));
      chk({tag, "_last"}, 64'(b.l), 64'(l));
      chk({tag, "_err"},  64'(b.e), 64'(e));
      if (l) chk({tag, "_len"}, 64'(b.n), 64'(n));
    end
  endtask

  task automatic send(input logic [1:0] rk, input logic [15:0] d);
    {rkm, rkl} = rk;
    rxd = d;
    @(negedge clk);
    #1;
  endtask

  task automatic s_idle();              send(2'b01, 16'hC5BC); endtask
  task automatic s_sof();               send(2'b11, 16'hFBFB); endtask
  task automatic s_eof();               send(2'b11, 16'hFDFD); endtask
  task automatic s_err();               send(2'b11, 16'hFEFE); endtask
  task automatic s_data(input logic [15:0] d); send(2'b00, d); endtask

  initial begin
    logic seen;
    int   irq_n;

    rst = 1'b0;
    rxd = '0;
    rkm = 1'b0;
    rkl = 1'b0;
    @(negedge clk);
    #1;
    repeat (3) s_data(16'h0);
    chk("rst_sync",  64'(o_sync), 64'd0);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_data",  o_data, 64'd0);
    chk("rst_fcnt",  64'(o_frame_cnt), 64'd0);
    chk("rst_cec",   64'(o_code_err_cnt), 64'd0);
    rst = 1'b1;
    repeat (2) s_data(16'h0);

    // sync acquire: broken run of 15, then a full run of 16
    seen = 1'b0;
    repeat (15) begin s_idle(); seen |= o_sync; end
    s_data(16'h1234);
    seen |= o_sync;
    repeat (15) begin s_idle(); seen |= o_sync; end
    chk("sync_early", 64'(seen), 64'd0);
    s_idle();
    chk("sync_e0", 64'(o_sync), 64'd0);
    s_idle();
    chk("sync_e1", 64'(o_sync), 64'd0);
    s_idle();
    chk("sync_e2", 64'(o_sync), 64'd1);

    // 8-word frame, with flush latency
    q.delete(); mq.delete();
    s_sof();
    for (int i = 0; i < 8; i++) s_data(16'(i));
    s_eof();
    chk("f8_lat0", 64'(q.size()), 64'd1);
    s_idle();
    chk("f8_lat1", 64'(q.size()), 64'd1);
    s_idle();
    chk("f8_lat2", 64'(q.size()), 64'd2);
    repeat (2) s_idle();
    chk_beat(0, "f8_b0", 0, 64'h0003_0002_0001_0000, 4'b1111, 1'b0, 1'b0, 16'd0);
    chk_beat(0, "f8_b1", 1, 64'h0007_0006_0005_0004, 4'b1111, 1'b1, 1'b0, 16'd8);
    chk("f8_nbeats", 64'(q.size()), 64'd2);
    chk("f8_fcnt", 64'(o_frame_cnt), 64'd1);
    chk("f8_len_hold", 64'(o_frame_len), 64'd8);

    // 6-word frame
    q.delete();
    s_sof();
    for (int i = 0; i < 6; i++) s_data(16'(16'h10 + i));
    s_eof();
    repeat (4) s_idle();
    chk_beat(0, "f6_b0", 0, 64'h0013_0012_0011_0010, 4'b1111, 1'b0, 1'b0, 16'd0);
    chk_beat(0, "f6_b1", 1, 64'h0000_0000_0015_0014, 4'b0011, 1'b1, 1'b0, 16'd6);
    chk("f6_fcnt", 64'(o_frame_cnt), 64'd2);

    // empty frame: counted, no beat
    q.delete();
    s_sof();
    s_eof();
    repeat (4) s_idle();
    chk("f0_nbeats", 64'(q.size()), 64'd0);
    chk("f0_fcnt", 64'(o_frame_cnt), 64'd3);

    // abort by IDLE after 5 words
    q.delete();
    s_sof();
    for (int i = 0; i < 5; i++) s_data(16'(16'h20 + i));
    s_idle();
    repeat (4) s_idle();
    chk_beat(0, "ab_b0", 0, 64'h0023_0022_0021_0020, 4'b1111, 1'b0, 1'b0, 16'd0);
    chk_beat(0, "ab_b1", 1, 64'h0000_0000_0000_0024, 4'b0001, 1'b1, 1'b1, 16'd5);
    chk("ab_fcnt", 64'(o_frame_cnt), 64'd3);

    // abort by SOF restart, back to back
    q.delete();
    s_sof();
    for (int i = 0; i < 3; i++) s_data(16'(16'h30 + i));
    s_sof();
    s_data(16'h40);
    s_data(16'h41);
    s_eof();
    repeat (4) s_idle();
    chk_beat(0, "rs_b0", 0, 64'h0000_0032_0031_0030, 4'b0111, 1'b1, 1'b1, 16'd3);
    chk_beat(0, "rs_b1", 1, 64'h0000_0000_0041_0040, 4'b0011, 1'b1, 1'b0, 16'd2);
    chk("rs_nbeats", 64'(q.size()), 64'd2);
    chk("rs_fcnt", 64'(o_frame_cnt), 64'd4);

    // overlong 10-word frame, then a short frame
    q.delete(); mq.delete();
    s_sof();
    for (int i = 0; i < 10; i++) s_data(16'(16'h50 + i));
    s_eof();
    s_idle();
    s_sof();
    s_data(16'h60);
    s_data(16'h61);
    s_eof();
    repeat (4) s_idle();
    chk_beat(0, "ol_b2", 2, 64'h0000_0000_0059_0058, 4'b0011, 1'b1, 1'b0, 16'd10);
    chk_beat(0, "ol_b3", 3, 64'h0000_0000_0061_0060, 4'b0011, 1'b1, 1'b0, 16'd2);
    chk("ol_fcnt", 64'(o_frame_cnt), 64'd6);
    chk_beat(1, "mx_b0", 0, 64'h0053_0052_0051_0050, 4'b1111, 1'b0, 1'b0, 16'd0);
    chk_beat(1, "mx_b1", 1, 64'h0057_0056_0055_0054, 4'b1111, 1'b1, 1'b1, 16'd8);
    chk_beat(1, "mx_b2", 2, 64'h0000_0000_0061_0060, 4'b0011, 1'b1, 1'b0, 16'd2);
    chk("mx_nbeats", 64'(mq.size()), 64'd3);
    chk("mx_fcnt", 64'(m_frame_cnt), 64'd4);

    // loss of sync on 8 code errors, then re-acquire
    repeat (7) s_err();
    repeat (2) s_idle();
    chk("loss_pre", 64'(o_sync), 64'd1);
    s_err();
    irq_n = 0;
    repeat (6) begin s_idle(); irq_n += int'(o_loss_irq); end
    chk("loss_irq", 64'(irq_n), 64'd1);
    chk("loss_sync", 64'(o_sync), 64'd0);
    chk("loss_cec", 64'(o_code_err_cnt), 64'd8);
    repeat (14) s_idle();
    chk("reacq_sync", 64'(o_sync), 64'd1);

    // async reset with a held group about to be emitted
    q.delete();
    s_sof();
    for (int i = 0; i < 4; i++) s_data(16'(16'h70 + i));
    rxd = 16'h0074;
    {rkm, rkl} = 2'b00;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(o_valid), 64'd0);
    chk("arst_sync",  64'(o_sync), 64'd0);
    chk("arst_data",  o_data, 64'd0);
    chk("arst_len",   64'(o_frame_len), 64'd0);
    chk("arst_fcnt",  64'(o_frame_cnt), 64'd0);
    chk("arst_cec",   64'(o_code_err_cnt), 64'd0);
    @(negedge clk);
    #1;
    repeat (2) s_data(16'h0075);
    rst = 1'b1;
    repeat (6) s_idle();
    chk("arst_nobeat", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
